// File: rtl/debug_uart_tx_sched.sv
// Shares one uart_tx between a CPU byte FIFO and a trace valid/ready source.
// Round-robin arbitration; one byte in flight; busy/level/overflow status for the CPU.
module debug_uart_tx_sched #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned START_TIMEOUT = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cpu_wr_en,
    input  logic [7:0]                      cpu_wr_data,
    output logic                            cpu_full,
    output logic [$clog2(FIFO_DEPTH):0]     cpu_level,
    output logic [7:0]                      drop_count,
    input  logic                            trc_valid,
    input  logic [7:0]                      trc_data,
    output logic                            trc_ready,
    output logic                            tx_en,
    output logic [7:0]                      tx_data,
    input  logic                            tx_busy,
    output logic                            busy
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned CntW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitStart,
        StWaitDone
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic [7:0]        drop_q, drop_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              last_trc_q, last_trc_d;
    logic [CntW-1:0]   tmo_q, tmo_d;

    logic cpu_req;
    logic full;
    logic can_grant;
    logic grant_cpu;
    logic pop;
    logic push;
    logic drop;

    // Arbitration: with both pending, serve whichever source was not served last.
    always_comb begin
        cpu_req   = (level_q != '0);
        full      = (level_q == LvlW'(FIFO_DEPTH));
        can_grant = (state_q == StIdle) && !tx_busy && (cpu_req || trc_valid);
        grant_cpu = cpu_req && (!trc_valid || last_trc_q);
        pop       = can_grant && grant_cpu;
        trc_ready = can_grant && !grant_cpu;
        // A full FIFO still accepts a write when the head leaves in the same cycle.
        push      = cpu_wr_en && (!full || pop);
        drop      = cpu_wr_en && !push;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        drop_d   = drop_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        tx_data_d  = tx_data_q;
        last_trc_d = last_trc_q;
        unique case (state_q)
            StIdle: begin
                if (can_grant) begin
                    tx_data_d  = grant_cpu ? mem_q[rd_ptr_q] : trc_data;
                    last_trc_d = !grant_cpu;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                tmo_d   = '0;
                state_d = StWaitStart;
            end
            StWaitStart: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (tmo_q == CntW'(START_TIMEOUT - 1)) begin
                    // uart_tx never started; the byte is abandoned rather than retried.
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + CntW'(1);
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            drop_q     <= '0;
            tx_data_q  <= '0;
            last_trc_q <= 1'b1;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            level_q    <= level_d;
            drop_q     <= drop_d;
            tx_data_q  <= tx_data_d;
            last_trc_q <= last_trc_d;
            tmo_q      <= tmo_d;
        end
    end

    // Storage needs no reset: entries are only read once the pointers mark them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= cpu_wr_data;
        end
    end

    always_comb begin
        tx_en      = (state_q == StIssue);
        tx_data    = tx_data_q;
        cpu_full   = full;
        cpu_level  = level_q;
        drop_count = drop_q;
        busy       = tx_busy || (state_q != StIdle) || (level_q != '0);
    end

endmodule

// File: tb/tb_debug_uart_tx_sched.sv
// Randomized bench for debug_uart_tx_sched: queue-based scheduler model plus a
// behavioural uart_tx responder, with random mid-run resets and a dead-UART phase.
module tb_debug_uart_tx_sched;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cpu_wr_en = 1'b0;
    logic [7:0] cpu_wr_data = 8'h00;
    logic       cpu_full;
    logic [2:0] cpu_level;
    logic [7:0] drop_count;
    logic       trc_valid = 1'b0;
    logic [7:0] trc_data = 8'h00;
    logic       trc_ready;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic       busy;

    always #5 clk = ~clk;

    debug_uart_tx_sched #(
        .FIFO_DEPTH   (DEPTH),
        .START_TIMEOUT(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_wr_en  (cpu_wr_en),
        .cpu_wr_data(cpu_wr_data),
        .cpu_full   (cpu_full),
        .cpu_level  (cpu_level),
        .drop_count (drop_count),
        .trc_valid  (trc_valid),
        .trc_data   (trc_data),
        .trc_ready  (trc_ready),
        .tx_en      (tx_en),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 issuing, 2 waiting for start, 3 waiting for done.
    byte unsigned q[$];
    int           m_phase;
    int           m_ws_left;
    bit           m_last_cpu;
    int           m_tx_data;
    int           m_drop;

    // uart_tx responder
    bit dead;
    int env_wait;
    int busy_left;
    int wr_pct;
    int trc_pct;
    int sent;

    task automatic model_reset();
        q.delete();
        m_phase    = 0;
        m_ws_left  = 0;
        m_last_cpu = 1'b0;
        m_tx_data  = 0;
        m_drop     = 0;
        env_wait   = -1;
        busy_left  = 0;
    endtask

    task automatic model_step(input bit gc, input bit gt);
        if (gc) begin
            m_tx_data  = q.pop_front();
            m_last_cpu = 1'b1;
        end
        if (gt) begin
            m_tx_data  = trc_data;
            m_last_cpu = 1'b0;
        end
        if (cpu_wr_en) begin
            if (q.size() < DEPTH) q.push_back(cpu_wr_data);
            else if (m_drop < 255) m_drop++;
        end
        case (m_phase)
            0: if (gc || gt) m_phase = 1;
            1: begin
                m_phase   = 2;
                m_ws_left = TMO;
            end
            2: begin
                if (tx_busy) m_phase = 3;
                else begin
                    m_ws_left--;
                    if (m_ws_left == 0) m_phase = 0;
                end
            end
            default: if (!tx_busy) m_phase = 0;
        endcase
    endtask

    task automatic cycle();
        bit gc, gt, te;
        @(negedge clk);
        gc = (m_phase == 0) && !tx_busy && (q.size() != 0) && (!trc_valid || !m_last_cpu);
        gt = (m_phase == 0) && !tx_busy && trc_valid && ((q.size() == 0) || m_last_cpu);
        te = (m_phase == 1);
        check("cpu_level", cpu_level, q.size());
        check("cpu_full", cpu_full, q.size() == DEPTH);
        check("drop_count", drop_count, m_drop);
        check("trc_ready", trc_ready, gt);
        check("tx_en", tx_en, te);
        check("tx_data", tx_data, m_tx_data);
        check("busy", busy, tx_busy || (m_phase != 0) || (q.size() != 0));
        if (te) sent++;
        @(posedge clk);
        if (rst_n) model_step(gc, gt);
        #1;
        if (rst_n) begin
            if (gt) trc_valid = 1'b0;
            if (busy_left > 0) busy_left--;
            if (te && !dead) env_wait = $urandom_range(0, 2);
            if (env_wait == 0) begin
                busy_left = $urandom_range(1, 4);
                env_wait  = -1;
            end else if (env_wait > 0) begin
                env_wait--;
            end
            tx_busy = (busy_left > 0);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        cpu_wr_en = 1'b0;
        trc_valid = 1'b0;
        tx_busy   = 1'b0;
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        sent = 0;
        do_reset();
        for (int seg = 0; seg < 4; seg++) begin
            dead    = (seg == 2);
            wr_pct  = (seg == 1) ? 75 : 30;
            trc_pct = (seg == 3) ? 60 : 25;
            for (int n = 0; n < 1500; n++) begin
                if ($urandom_range(0, 399) == 0) do_reset();
                cpu_wr_en   = ($urandom_range(0, 99) < wr_pct);
                cpu_wr_data = 8'($urandom);
                if (!trc_valid && ($urandom_range(0, 99) < trc_pct)) begin
                    trc_valid = 1'b1;
                    trc_data  = 8'($urandom);
                end
                cycle();
            end
        end
        cpu_wr_en = 1'b0;
        trc_valid = 1'b0;
        for (int n = 0; n < 40; n++) cycle();
        check("bytes_issued_nonzero", sent > 100, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
